// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational MIPS-style ALU plus an iterative unsigned multiply/divide
// unit with architectural HI/LO registers and a start/busy/done handshake.
// Optional divider: define ALU_MULDIV_DIV_EN to build it; otherwise DIV completes
// immediately and leaves HI/LO untouched.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_op,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = ShW + 1;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSrl  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpMult = 4'b1000;
  localparam logic [3:0] OpDiv  = 4'b1001;
  localparam logic [3:0] OpMfhi = 4'b1010;
  localparam logic [3:0] OpMflo = 4'b1011;
  localparam logic [3:0] OpNor  = 4'b1100;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc_hi/acc_lo: {partial product, multiplier} for MULT, {remainder, quotient} for DIV.
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              op_div_q, op_div_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              accept;

  // Shift-add multiply step: conditionally add multiplicand, then shift the pair right.
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  mul_hi_nxt, mul_lo_nxt;
  assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

`ifdef ALU_MULDIV_DIV_EN
  // Restoring divide step. With a zero divisor every step subtracts nothing, so the
  // quotient fills with ones and the remainder ends up equal to the dividend.
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
  logic              div_ge;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;
`endif

  assign accept = start && (state_q == StIdle) && ((alu_op == OpMult) || (alu_op == OpDiv));
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Next-state logic for the multiply/divide sequencer and its datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    op_div_d = op_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_div_d = (alu_op == OpDiv);
          b_d      = in2;
          acc_hi_d = '0;
          acc_lo_d = in1;
          cnt_d    = CntW'(WIDTH);
          state_d  = StRun;
`ifndef ALU_MULDIV_DIV_EN
          if (alu_op == OpDiv) state_d = StFin;
`endif
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
`ifdef ALU_MULDIV_DIV_EN
        if (op_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_hi_nxt;
          acc_lo_d = mul_lo_nxt;
        end
`else
        acc_hi_d = mul_hi_nxt;
        acc_lo_d = mul_lo_nxt;
`endif
        if (cnt_q == CntW'(1)) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
        hi_d = acc_hi_q;
        lo_d = acc_lo_q;
`else
        if (!op_div_q) begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      op_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      op_div_q <= op_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Combinational result mux; MULT/DIV and unknown codes read as zero.
  always_comb begin
    out = '0;
    case (alu_op)
      OpAnd:  out = in1 & in2;
      OpOr:   out = in1 | in2;
      OpNor:  out = ~(in1 | in2);
      OpAdd:  out = in1 + in2;
      OpSub:  out = in1 - in2;
      OpSlt:  out = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OpSll:  out = in1 << in2[ShW-1:0];
      OpSrl:  out = in1 >> in2[ShW-1:0];
      OpMfhi: out = hi_q;
      OpMflo: out = lo_q;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32). Expected HI/LO and completion cycle are
// queued when a start is issued; a monitor pops and checks on every done pulse.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSrl  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpMult = 4'b1000;
  localparam logic [3:0] OpDiv  = 4'b1001;
  localparam logic [3:0] OpMfhi = 4'b1010;
  localparam logic [3:0] OpMflo = 4'b1011;
  localparam logic [3:0] OpNor  = 4'b1100;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in1, in2;
  logic [3:0]   alu_op;
  logic         start;
  logic [W-1:0] out, hi, lo;
  logic         zero, busy, done;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .alu_op(alu_op), .start(start),
    .out(out), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k (sampled #1 later or at the next negedge) cyc == k.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  cyc;
  } exp_t;
  exp_t sb[$];

  int ntests = 0;
  int nfail  = 0;
  int ndone  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      ndone++;
      if (sb.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_hi", hi, e.hi);
        chk("done_lo", lo, e.lo);
        chk("done_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Drive a start for one edge; lat is edges from the accepting edge to done visibility.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int unsigned lat);
    exp_t e;
    alu_op = op; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.hi = eh; e.lo = el; e.cyc = cyc + lat;
      sb.push_back(e);
    end
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == max) begin
      ntests++;
      nfail++;
      $display("FAIL done_timeout: got no done expected one within %0d cycles", max);
    end
  endtask

  task automatic comb(input string name, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp_out);
    alu_op = op; in1 = a; in2 = b;
    #1;
    chk(name, out, exp_out);
    chk({name, "_zero"}, W'(zero), W'(exp_out == '0));
  endtask

  localparam int unsigned MulLat = W + 1;
`ifdef ALU_MULDIV_DIV_EN
  localparam int unsigned DivLat = W + 1;
`else
  localparam int unsigned DivLat = 1;
`endif

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; alu_op = OpAdd;
    repeat (2) @(posedge clk);
    // Reset together with start: start must be dropped.
    alu_op = OpMult; in1 = 32'd3; in2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);

    comb("add", OpAdd, 32'd5, 32'd7, 32'd12);
    comb("sub_zero", OpSub, 32'd7, 32'd7, 32'd0);
    comb("sub_wrap", OpSub, 32'd0, 32'd1, 32'hFFFF_FFFF);
    comb("slt_neg", OpSlt, 32'hFFFF_FFFF, 32'd1, 32'd1);
    comb("slt_pos", OpSlt, 32'd1, 32'hFFFF_FFFF, 32'd0);
    comb("and", OpAnd, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
    comb("or", OpOr, 32'hF0F0_0000, 32'h0000_1234, 32'hF0F0_1234);
    comb("nor", OpNor, 32'd0, 32'd0, 32'hFFFF_FFFF);
    comb("sll", OpSll, 32'd1, 32'd31, 32'h8000_0000);
    comb("srl", OpSrl, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    comb("undef_op", 4'b1111, 32'hFFFF_FFFF, 32'h1, 32'd0);
    comb("mult_op_out", OpMult, 32'd3, 32'd4, 32'd0);

    // Start with a non-MULT/DIV op is ignored.
    issue(OpAdd, 32'd1, 32'd2, 1'b0, '0, '0, 0);
    chk("nonmd_start_busy", W'(busy), '0);

    // MULT all-ones squared, with operand change and a stray start mid-run.
    issue(OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, MulLat);
    chk("mult_busy", W'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    in1 = '0;
    repeat (3) @(posedge clk);
    issue(OpMult, 32'd2, 32'd2, 1'b0, '0, '0, 0);
    alu_op = OpMfhi;
    #1;
    chk("mfhi_during_busy", out, 32'd0);
    wait_done(60);
    @(negedge clk);
    chk("done_pulse_end", W'(done), '0);
    chk("busy_after_done", W'(busy), '0);
    alu_op = OpMfhi;
    #1;
    chk("mfhi_after_mult", out, 32'hFFFF_FFFE);

    // DIV 100/7 and 9/0.
`ifdef ALU_MULDIV_DIV_EN
    issue(OpDiv, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, DivLat);
`else
    issue(OpDiv, 32'd100, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, DivLat);
`endif
    chk("div_busy", W'(busy), 32'd1);
    wait_done(60);
    @(posedge clk); #1;
`ifdef ALU_MULDIV_DIV_EN
    issue(OpDiv, 32'd9, 32'd0, 1'b1, 32'd9, 32'hFFFF_FFFF, DivLat);
`else
    issue(OpDiv, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, DivLat);
`endif
    wait_done(60);
    @(posedge clk); #1;

    // Reset 10 cycles into a MULT aborts it with no done.
    issue(OpMult, 32'd3, 32'd5, 1'b0, '0, '0, 0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", W'(busy), '0);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    begin
      int d0;
      d0 = ndone;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", W'(ndone - d0), '0);
    end

    // Back-to-back: second MULT started in the done cycle of the first.
    issue(OpMult, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, MulLat);
    wait_done(60);
    issue(OpMult, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, MulLat);
    chk("b2b_busy", W'(busy), 32'd1);
    alu_op = OpMflo;
    #1;
    chk("b2b_mflo_old", out, 32'd42);
    wait_done(60);
    @(posedge clk); #1;
    alu_op = OpMflo;
    #1;
    chk("b2b_mflo_new", out, 32'd12);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
